// File: rtl/pipe_mult_pkg.sv
// Shared types and constants for the pipelined multiplier.
// Hazard ports are built only when PIPE_MULT_HAZARD_EN is defined.
package pipe_mult_pkg;

    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 8;
    localparam int WIDTH_MIN  = 8;
    localparam int WIDTH_MAX  = 64;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAGW  = 5;

    typedef struct packed {
        logic                   valid;
        logic [DEF_TAGW-1:0]    tag;
        logic [2*DEF_WIDTH-1:0] product;
    } stage_rec_t;

endpackage

// File: rtl/pipe_mult_stage.sv
// One pipeline register of the multiplier: hold on stall, clear on flush.
// Record type is supplied by the parent so widths follow its parameters.
module pipe_mult_stage
    import pipe_mult_pkg::*;
#(
    parameter type rec_t = stage_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold_i,
    input  logic clear_i,
    input  rec_t d_i,
    output rec_t q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (clear_i) begin
            q_o <= '0;
        end else if (!hold_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_mult_unit.sv
// Pipelined signed/unsigned multiplier with stall, flush and tag tracking.
// Define PIPE_MULT_HAZARD_EN to add chk_rs1/chk_rs2 and the hazard output.
module pipe_mult_unit
    import pipe_mult_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAGW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sign_mode,
    input  logic [TAGW-1:0]      in_tag,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAGW-1:0]      out_tag,
    output logic                 busy
`ifdef PIPE_MULT_HAZARD_EN
    ,
    input  logic [TAGW-1:0]      chk_rs1,
    input  logic [TAGW-1:0]      chk_rs2,
    output logic                 hazard
`endif
);

    typedef struct packed {
        logic               valid;
        logic [TAGW-1:0]    tag;
        logic [2*WIDTH-1:0] product;
    } rec_t;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        STAGES < STAGES_MIN || STAGES > STAGES_MAX ||
        TAGW < 1) begin : g_bad_param
        $error("pipe_mult_unit: parameter out of range");
    end

    rec_t               pipe [STAGES];
    rec_t               st1_d;
    rec_t               st1_q;
    logic [2*WIDTH-1:0] op_a;
    logic [2*WIDTH-1:0] op_b;

    assign in_ready = ~stall & ~flush;

    always_comb begin
        op_a = {{WIDTH{1'b0}}, a};
        op_b = {{WIDTH{1'b0}}, b};
        case (sign_mode)
            MODE_SIGNED: begin
                op_a = {{WIDTH{a[WIDTH-1]}}, a};
                op_b = {{WIDTH{b[WIDTH-1]}}, b};
            end
            MODE_UNSIGNED: ;
            default: ;
        endcase
        // Low 2W bits of the extended product are exact for both modes.
        st1_d.valid   = in_valid & in_ready;
        st1_d.tag     = in_tag;
        st1_d.product = op_a * op_b;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st1_q <= '0;
        end else if (flush) begin
            st1_q <= '0;
        end else if (!stall) begin
            st1_q <= st1_d;
        end
    end

    assign pipe[0] = st1_q;

    for (genvar i = 1; i < STAGES; i++) begin : g_stage
        pipe_mult_stage #(
            .rec_t(rec_t)
        ) u_stage (
            .clk    (clk),
            .rst_n  (reset),
            .hold_i (stall),
            .clear_i(flush),
            .d_i    (pipe[i-1]),
            .q_o    (pipe[i])
        );
    end

    assign out_valid   = pipe[STAGES-1].valid;
    assign out_tag     = pipe[STAGES-1].tag;
    assign out_product = pipe[STAGES-1].valid ?
                         pipe[STAGES-1].product : '0;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            busy = busy | pipe[i].valid;
        end
    end

`ifdef PIPE_MULT_HAZARD_EN
    // Tag 0 is never a real destination, so it never matches.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (pipe[i].valid &&
                ((chk_rs1 != '0 && pipe[i].tag == chk_rs1) ||
                 (chk_rs2 != '0 && pipe[i].tag == chk_rs2))) begin
                hazard = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mult_unit.sv
// Directed bench for pipe_mult_unit with a queue-based reference model.
// Hazard checks are included when PIPE_MULT_HAZARD_EN is defined.
module tb_pipe_mult_unit;

    localparam int WIDTH  = 32;
    localparam int STAGES = 3;
    localparam int TAGW   = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 sign_mode;
    logic [TAGW-1:0]      in_tag;
    logic                 stall;
    logic                 flush;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   out_product;
    logic [TAGW-1:0]      out_tag;
    logic                 busy;
    logic [TAGW-1:0]      chk_rs1;
    logic [TAGW-1:0]      chk_rs2;
`ifdef PIPE_MULT_HAZARD_EN
    logic                 hazard;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_mult_unit #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .TAGW  (TAGW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sign_mode  (sign_mode),
        .in_tag     (in_tag),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_product(out_product),
        .out_tag    (out_tag),
        .busy       (busy)
`ifdef PIPE_MULT_HAZARD_EN
        ,
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .hazard     (hazard)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: an accepted op is a queue entry aged by unstalled edges.
    typedef struct {
        logic [TAGW-1:0] tag;
        logic [63:0]     prod;
        int              age;
    } op_t;

    op_t mq[$];

    function automatic logic [63:0] ref_mul(logic [31:0] x,
                                            logic [31:0] y,
                                            logic s);
        logic signed [63:0] r;
        logic [63:0]        u;
        if (s) begin
            r = $signed(x) * $signed(y);
            return r;
        end
        u = x * y;
        return u;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            mq.delete();
        end else if (!stall) begin
            foreach (mq[i]) mq[i].age++;
            while (mq.size() > 0 && mq[0].age > STAGES)
                void'(mq.pop_front());
            if (in_valid)
                mq.push_back('{tag: in_tag,
                               prod: ref_mul(a, b, sign_mode),
                               age: 1});
        end
    end

    always @(negedge clk) begin
        logic            ev;
        logic [TAGW-1:0] et;
        logic [63:0]     ep;
        logic            eh;
        ev = 1'b0;
        et = '0;
        ep = '0;
        eh = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].age == STAGES) begin
                ev = 1'b1;
                et = mq[i].tag;
                ep = mq[i].prod;
            end
            if ((chk_rs1 != 0 && mq[i].tag == chk_rs1) ||
                (chk_rs2 != 0 && mq[i].tag == chk_rs2))
                eh = 1'b1;
        end
        chk("m_out_valid", out_valid, ev);
        chk("m_out_product", out_product, ep);
        if (ev || !reset) chk("m_out_tag", out_tag, et);
        chk("m_busy", busy, mq.size() != 0);
        chk("m_in_ready", in_ready, !stall && !flush);
`ifdef PIPE_MULT_HAZARD_EN
        chk("m_hazard", hazard, eh);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [31:0] x, logic [31:0] y,
                         logic s, logic [TAGW-1:0] t);
        a         = x;
        b         = y;
        sign_mode = s;
        in_tag    = t;
        in_valid  = 1'b1;
    endtask

    logic [31:0]     ta [6];
    logic [31:0]     tb [6];
    logic            ts [6];
    int              cnt;

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sign_mode = 1'b0;
        in_tag = '0;
        stall = 1'b0;
        flush = 1'b0;
        chk_rs1 = '0;
        chk_rs2 = '0;
        ta = '{32'h0, 32'h1, 32'h80000000,
               32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF};
        tb = '{32'h5, 32'hFFFFFFFF, 32'h80000000,
               32'h7FFFFFFF, 32'h9ABCDEF0, 32'hFFFFFFFF};
        ts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (2) tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_tag", out_tag, '0);

        reset = 1'b1;
        issue(32'hFFFFFFFD, 32'd7, 1'b1, 5'd4);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("neg3x7_valid", out_valid, 1'b1);
        chk("neg3x7_prod", out_product, 64'hFFFFFFFFFFFFFFEB);
        chk("neg3x7_tag", out_tag, 5'd4);
        tick();
        chk("neg3x7_gone", out_valid, 1'b0);
        repeat (2) tick();

        issue(32'hFFFFFFFF, 32'd2, 1'b0, 5'd1);
        tick();
        issue(32'hFFFFFFFF, 32'd2, 1'b1, 5'd2);
        tick();
        in_valid = 1'b0;
        tick();
        chk("umax_x2", out_product, 64'h00000001FFFFFFFE);
        tick();
        chk("smax_x2", out_product, 64'hFFFFFFFFFFFFFFFE);
        chk("smax_x2_tag", out_tag, 5'd2);
        repeat (3) tick();

        issue(32'd3, 32'd3, 1'b0, 5'd3);
        tick();
        issue(32'd4, 32'd4, 1'b0, 5'd5);
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        #1;
        chk("stall_ready", in_ready, 1'b0);
        tick();
        tick();
        stall = 1'b0;
        tick();
        chk("stall_c5_valid", out_valid, 1'b1);
        chk("stall_c5_tag", out_tag, 5'd3);
        tick();
        chk("stall_c6_tag", out_tag, 5'd5);
        chk("stall_c6_prod", out_product, 64'd16);
        repeat (3) tick();

        issue(32'd6, 32'd6, 1'b0, 5'd6);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        tick();
        chk("hold_c4_valid", out_valid, 1'b1);
        chk("hold_c4_tag", out_tag, 5'd6);
        tick();
        chk("hold_c5_prod", out_product, 64'd36);
        stall = 1'b0;
        tick();
        chk("hold_release", out_valid, 1'b0);
        repeat (2) tick();

        issue(32'd7, 32'd7, 1'b0, 5'd7);
        tick();
        issue(32'd8, 32'd8, 1'b0, 5'd8);
        tick();
        issue(32'd10, 32'd10, 1'b0, 5'd10);
        flush = 1'b1;
        #1;
        chk("flush_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", busy, 1'b0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) cnt++;
            tick();
        end
        chk("flush_no_out", cnt, 0);

        cnt = 0;
        for (int c = 0; c < 9; c++) begin
            if (c < 6) issue(ta[c], tb[c], ts[c], 5'(11 + c));
            else in_valid = 1'b0;
            if (out_valid) cnt++;
            if (c == 5) chk("min_sq", out_product, 64'h4000000000000000);
            tick();
        end
        chk("stream_count", cnt, 6);
        repeat (2) tick();

`ifdef PIPE_MULT_HAZARD_EN
        issue(32'd1, 32'd1, 1'b0, 5'd9);
        chk_rs1 = 5'd9;
        tick();
        chk("haz_tag9", hazard, 1'b1);
        issue(32'd2, 32'd2, 1'b0, 5'd0);
        tick();
        in_valid = 1'b0;
        chk_rs1 = '0;
        #1;
        chk("haz_tag0", hazard, 1'b0);
        tick();
        chk_rs1 = 5'd9;
        #1;
        chk("haz_last", hazard, 1'b1);
        tick();
        chk("haz_exit", hazard, 1'b0);
        chk_rs1 = '0;
        repeat (3) tick();
`endif

        issue(32'd9, 32'd9, 1'b0, 5'd20);
        tick();
        issue(32'd5, 32'd5, 1'b0, 5'd21);
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_valid", out_valid, 1'b0);
        chk("async_prod", out_product, 64'd0);
        chk("async_busy", busy, 1'b0);
        tick();
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) cnt++;
            tick();
        end
        chk("rst_lost", cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
